img_sensor_tx: RTL and testbench
================================

// Module: img_sensor_tx
// PURPOSE
//  Synthesizable image-sensor transmitter: the sensor end of the img_fv/img_lv/img_d parallel pixel bus that ImgController receives.
//  Emits one frame of a deterministic ramp pattern per capture command.
//  Used on-chip for sensor-less bring-up and as a pattern source in ImgController regression benches.
// PARAMETERS
//  ImgWidth      2304  active pixels per line (>=1)
//  ImgHeight     1296  active lines per frame (>=1)
//  HBlank        16    clk cycles with lv=0 between lines, fv=1 (>=1)
//  VBlankPre     8     clk cycles of fv=1 before the first line (>=1)
//  VBlankPost    8     clk cycles of fv=1 after the last line (>=1)
//  PixelInitial  12'hFFF  value of the first pixel of each frame
//  PixelDelta    -1    signed per-pixel increment, applied modulo 2^12
// PORTS
//  clk                     in   1   pixel clock; img_dclk is a direct copy of clk
//  rst                     in   1   asynchronous active-high reset
//  cmd_capture             in   1   toggle; each change requests one frame
//  status_busy             out  1   1 from the cycle after an accepted toggle until the end of FvPost
//  status_captureDone      out  1   toggles once per completed frame
//  status_pixelCount       out  RegWidth(ImgWidth*ImgHeight)  pixels sent in the last completed frame
//  img_dclk                out  1   = clk
//  img_fv                  out  1   frame valid, registered
//  img_lv                  out  1   line valid, registered
//  img_d                   out  12  pixel data, registered; 0 whenever lv=0
// BEHAVIOUR
//  - Reset (async): state=Idle; fv=lv=0; d=0; busy=0; captureDone=0; pixelCount=0; toggle history := cmd_capture.
//  - Toggle detect: cmd_capture is sampled every clk.
//  - A change seen while in Idle is accepted; it enters FvPre on the next edge.
//  - A change seen in any other state is discarded, not queued. The history register updates every cycle regardless.
//  - FSM (all outputs registered; values below are the values during the state):
//    Idle:    fv=0 lv=0.
//    FvPre:   fv=1 lv=0 for VBlankPre cycles, then Line with row=0.
//    Line:    fv=1 lv=1 for ImgWidth cycles; d=pix.
//             pix <= pix+PixelDelta (12-bit wrap).
//             At the end of the line: to FvPost if row==ImgHeight-1, else to HBlank with row++.
//    HBlank:  fv=1 lv=0 for HBlank cycles, then Line.
//    FvPost:  fv=1 lv=0 for VBlankPost cycles.
//             On exit: Idle; captureDone toggles; pixelCount <= frame pixel counter; busy falls.
//  - pix reloads to PixelInitial on entry to FvPre. The pattern runs continuously across line boundaries; it is not reset per line.
//  - Frame pixel counter:
//    - cleared on entry to FvPre;
//    - incremented on every lv=1 cycle;
//    - saturates at all-ones; it never wraps.
//  - fv high duration = VBlankPre + ImgHeight*ImgWidth + (ImgHeight-1)*HBlank + VBlankPost cycles exactly.
//  - lv is only ever 1 while fv is 1. fv and lv never rise or fall on the same edge.
//  - Latency: the toggle changes at edge N; fv rises at edge N+2 (one sample edge plus one state edge).
//  - status_pixelCount updates on the same edge that captureDone toggles, so it is stable when the toggle is observed.
//  - Reset mid-frame: outputs drop immediately (asynchronously).
//    - No captureDone toggle is produced for the aborted frame.
//    - pixelCount returns to 0.
//  - Counters: per-state cycle counter width = RegWidth(max(ImgWidth,HBlank,VBlankPre,VBlankPost)); row counter width = RegWidth(ImgHeight).
// TESTING (ImgWidth=4 ImgHeight=3 HBlank=2 VBlankPre=3 VBlankPost=2)
//  1. Toggle cmd_capture once:
//     - fv high exactly 21 cycles, lv high 3 bursts of 4;
//     - d = FFF,FFE,...,FF4;
//     - captureDone toggles once; pixelCount = 12.
//  2. Cycle-count check: fv rises 2 edges after the toggle; lv rises 3 cycles after fv; the gap between lv bursts is exactly 2.
//  3. PixelInitial=12'h001:
//     - d sequence = 001,000,FFF,FFE,...,FF6 (wrap);
//     - second frame restarts at 001.
//  4. Toggle again mid-frame (cycle 10 of fv):
//     - the frame completes unchanged;
//     - exactly one captureDone toggle;
//     - no second frame follows.
//  5. Assert rst at lv cycle 2 of row 1:
//     - fv/lv/d go 0 in the same delta;
//     - captureDone is unchanged, pixelCount = 0;
//     - the next toggle produces a clean full frame.
//  6. Loopback into ImgController at defaults: capture reports pixelCount = ImgWidth*ImgHeight, and the readout ramp validates.

Source files
------------

// File: rtl/img_sensor_tx.sv
// img_sensor_tx: sensor end of the fv/lv/d parallel pixel bus.
// Each change on cmd_capture starts one frame of a ramp pattern. The ramp
// starts at PixelInitial and steps by PixelDelta (modulo 2^12) on every
// active pixel. All bus and status outputs are registered.
module img_sensor_tx #(
    parameter int          ImgWidth     = 2304,
    parameter int          ImgHeight    = 1296,
    parameter int          HBlank       = 16,
    parameter int          VBlankPre    = 8,
    parameter int          VBlankPost   = 8,
    parameter logic [11:0] PixelInitial = 12'hFFF,
    parameter int          PixelDelta   = -1,
    localparam int         PixW         = $clog2(ImgWidth * ImgHeight + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_capture,
    output logic            status_busy,
    output logic            status_captureDone,
    output logic [PixW-1:0] status_pixelCount,
    output logic            img_dclk,
    output logic            img_fv,
    output logic            img_lv,
    output logic [11:0]     img_d
);

    localparam int MaxA   = (ImgWidth > HBlank) ? ImgWidth : HBlank;
    localparam int MaxB   = (VBlankPre > VBlankPost) ? VBlankPre : VBlankPost;
    localparam int MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int CntW   = $clog2(MaxCnt + 1);
    localparam int RowW   = $clog2(ImgHeight + 1);

    localparam logic [CntW-1:0] PreLast  = CntW'(VBlankPre - 1);
    localparam logic [CntW-1:0] LineLast = CntW'(ImgWidth - 1);
    localparam logic [CntW-1:0] HbLast   = CntW'(HBlank - 1);
    localparam logic [CntW-1:0] PostLast = CntW'(VBlankPost - 1);
    localparam logic [RowW-1:0] RowLast  = RowW'(ImgHeight - 1);
    localparam logic [11:0]     PixStep  = 12'(PixelDelta);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FVPRE,
        ST_LINE,
        ST_HBLANK,
        ST_FVPOST
    } state_t;

    state_t          state_q;
    logic [CntW-1:0] cnt_q;
    logic [RowW-1:0] row_q;
    logic [11:0]     pix_q, pix_d;
    logic [PixW-1:0] fpc_q, fpc_d;
    logic [PixW-1:0] pcnt_q;
    logic            fv_q, lv_q, busy_q, done_q;
    logic [11:0]     d_q;
    logic            hist_q, hist_vld_q, tog_q;

    assign img_dclk           = clk;
    assign img_fv             = fv_q;
    assign img_lv             = lv_q;
    assign img_d              = d_q;
    assign status_busy        = busy_q;
    assign status_captureDone = done_q;
    assign status_pixelCount  = pcnt_q;

    // Next ramp value and saturating frame pixel count.
    always_comb begin
        pix_d = pix_q + PixStep;
        fpc_d = (fpc_q == '1) ? fpc_q : fpc_q + PixW'(1);
    end

    // Toggle detect. The history reloads from cmd_capture on the first edge
    // after reset, so the level held during reset is never taken as a change.
    // tog_q adds the sample stage: a toggle that changes on edge N puts fv up on edge N+2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q     <= 1'b0;
            hist_vld_q <= 1'b0;
            tog_q      <= 1'b0;
        end else begin
            hist_q     <= cmd_capture;
            hist_vld_q <= 1'b1;
            tog_q      <= hist_vld_q && (cmd_capture != hist_q);
        end
    end

    // Frame sequencer. Outputs are set on the edge that enters each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            pix_q   <= PixelInitial;
            fpc_q   <= '0;
            pcnt_q  <= '0;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (lv_q) fpc_q <= fpc_d;
            case (state_q)
                ST_IDLE: begin
                    // A toggle seen in any other state is dropped.
                    if (tog_q) begin
                        state_q <= ST_FVPRE;
                        cnt_q   <= '0;
                        pix_q   <= PixelInitial;
                        fpc_q   <= '0;
                        fv_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FVPRE: begin
                    if (cnt_q == PreLast) begin
                        state_q <= ST_LINE;
                        cnt_q   <= '0;
                        row_q   <= '0;
                        lv_q    <= 1'b1;
                        d_q     <= pix_q;
                        pix_q   <= pix_d;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                ST_LINE: begin
                    if (cnt_q == LineLast) begin
                        cnt_q <= '0;
                        lv_q  <= 1'b0;
                        d_q   <= '0;
                        if (row_q == RowLast) begin
                            state_q <= ST_FVPOST;
                        end else begin
                            state_q <= ST_HBLANK;
                            row_q   <= row_q + RowW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        d_q   <= pix_q;
                        pix_q <= pix_d;
                    end
                end
                ST_HBLANK: begin
                    if (cnt_q == HbLast) begin
                        state_q <= ST_LINE;
                        cnt_q   <= '0;
                        lv_q    <= 1'b1;
                        d_q     <= pix_q;
                        pix_q   <= pix_d;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                ST_FVPOST: begin
                    if (cnt_q == PostLast) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        fv_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= ~done_q;
                        pcnt_q  <= fpc_q;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_sensor_tx.sv
// Bench for img_sensor_tx: two instances (ramp from FFF and from 001) share
// clock, reset and command. Each frame is checked cycle by cycle against a
// frame model computed from the timing parameters.
module tb_img_sensor_tx;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int HB    = 2;
    localparam int VPRE  = 3;
    localparam int VPOST = 2;
    localparam int TOTAL = VPRE + W * H + (H - 1) * HB + VPOST; // 21
    localparam int NPIX  = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd;
    logic       busy_a, done_a, dclk_a, fv_a, lv_a;
    logic       busy_b, done_b, dclk_b, fv_b, lv_b;
    logic [3:0] pc_a, pc_b;
    logic [11:0] d_a, d_b;

    int checks = 0;
    int errors = 0;
    logic exp_done = 1'b0;

    always #5 clk = ~clk;

    img_sensor_tx #(.ImgWidth(W), .ImgHeight(H), .HBlank(HB), .VBlankPre(VPRE),
                    .VBlankPost(VPOST), .PixelInitial(12'hFFF), .PixelDelta(-1)) dut_a (
        .clk(clk), .rst(rst), .cmd_capture(cmd), .status_busy(busy_a),
        .status_captureDone(done_a), .status_pixelCount(pc_a), .img_dclk(dclk_a),
        .img_fv(fv_a), .img_lv(lv_a), .img_d(d_a));

    img_sensor_tx #(.ImgWidth(W), .ImgHeight(H), .HBlank(HB), .VBlankPre(VPRE),
                    .VBlankPost(VPOST), .PixelInitial(12'h001), .PixelDelta(-1)) dut_b (
        .clk(clk), .rst(rst), .cmd_capture(cmd), .status_busy(busy_b),
        .status_captureDone(done_b), .status_pixelCount(pc_b), .img_dclk(dclk_b),
        .img_fv(fv_b), .img_lv(lv_b), .img_d(d_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {fv,lv,d} for cycle k of a frame (k=0 is the first fv cycle).
    function automatic logic [13:0] exp_at(input int k, input logic [11:0] init);
        int p, r, c;
        if (k < VPRE) return {2'b10, 12'h000};
        p = k - VPRE;
        r = p / (W + HB);
        c = p % (W + HB);
        if (r < H && c < W) return {2'b11, 12'(int'(init) - (r * W + c))};
        if (k < TOTAL) return {2'b10, 12'h000};
        return 14'h0;
    endfunction

    task automatic chk_cycle(input string tag, input int k);
        logic [13:0] ea, eb;
        ea = exp_at(k, 12'hFFF);
        eb = exp_at(k, 12'h001);
        chk($sformatf("%s_a_k%0d", tag, k), {busy_a, fv_a, lv_a, d_a}, {ea[13], ea});
        chk($sformatf("%s_b_k%0d", tag, k), {busy_b, fv_b, lv_b, d_b}, {eb[13], eb});
        chk($sformatf("%s_dclk_k%0d", tag, k), {dclk_a, dclk_b}, 2'b00);
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {busy_a, fv_a, lv_a, d_a, busy_b, fv_b, lv_b, d_b}, 30'h0);
    endtask

    // One frame: optional idle gap, toggle, latency check, full frame compare,
    // optional discarded toggle at fv cycle mid_k, then status check.
    task automatic run_frame(input int gap, input int mid_k,
                             output logic [11:0] fa, output logic [11:0] la,
                             output logic [11:0] fb, output logic [11:0] lb);
        bit seen;
        seen = 1'b0;
        fa = '0; la = '0; fb = '0; lb = '0;
        repeat (gap) begin
            @(negedge clk);
            chk_idle("gap_idle");
        end
        @(posedge clk);
        #1 cmd = ~cmd;
        @(negedge clk);
        chk_idle("lat_n");
        @(posedge clk);
        @(negedge clk);
        chk_idle("lat_n1");
        for (int k = 0; k <= TOTAL; k++) begin
            @(posedge clk);
            #1 if (k == mid_k) cmd = ~cmd;
            @(negedge clk);
            chk_cycle("frm", k);
            if (lv_a) begin
                if (!seen) begin fa = d_a; fb = d_b; seen = 1'b1; end
                la = d_a; lb = d_b;
            end
        end
        exp_done = ~exp_done;
        chk("done_a", done_a, exp_done);
        chk("done_b", done_b, exp_done);
        chk("pcnt_a", pc_a, NPIX);
        chk("pcnt_b", pc_b, NPIX);
        // No frame may follow a discarded toggle.
        repeat (4) begin
            @(negedge clk);
            chk_idle("post_idle");
        end
        chk("done_hold", {done_a, done_b}, {exp_done, exp_done});
    endtask

    typedef struct {
        int          gap;
        int          mid_k;
        logic [11:0] fa, la, fb, lb;
    } vec_t;

    initial begin
        vec_t vecs[4];
        logic [11:0] fa, la, fb, lb;
        int nfr;

        vecs[0] = '{gap: 2, mid_k: -1, fa: 12'hFFF, la: 12'hFF4, fb: 12'h001, lb: 12'hFF6};
        vecs[1] = '{gap: 0, mid_k: 10, fa: 12'hFFF, la: 12'hFF4, fb: 12'h001, lb: 12'hFF6};
        vecs[2] = '{gap: 5, mid_k: -1, fa: 12'hFFF, la: 12'hFF4, fb: 12'h001, lb: 12'hFF6};
        vecs[3] = '{gap: 1, mid_k: 3,  fa: 12'hFFF, la: 12'hFF4, fb: 12'h001, lb: 12'hFF6};

        rst = 1'b1;
        cmd = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("rst_idle");
        chk("rst_status", {done_a, pc_a, done_b, pc_b}, 10'h0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_idle("post_rst_idle");
        end

        // Directed table: boundary values of the ramp for each instance.
        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].gap, vecs[i].mid_k, fa, la, fb, lb);
            chk($sformatf("tbl%0d_first_a", i), fa, vecs[i].fa);
            chk($sformatf("tbl%0d_last_a", i),  la, vecs[i].la);
            chk($sformatf("tbl%0d_first_b", i), fb, vecs[i].fb);
            chk($sformatf("tbl%0d_last_b", i),  lb, vecs[i].lb);
        end

        // Random gaps and random discarded mid-frame toggles.
        nfr = 6;
        for (int i = 0; i < nfr; i++) begin
            int g, mk;
            g  = $urandom_range(0, 5);
            mk = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 18);
            run_frame(g, mk, fa, la, fb, lb);
        end

        // Reset mid-frame with captureDone at 0 so its reset value equals its old value.
        if (exp_done) run_frame(1, -1, fa, la, fb, lb);
        @(posedge clk);
        #1 cmd = ~cmd;
        @(posedge clk);
        for (int k = 0; k <= VPRE + W + HB + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk_cycle("pre_rst", k);
        end
        rst = 1'b1;
        #1;
        chk_idle("async_rst_out");
        chk("async_rst_status", {done_a, pc_a, done_b, pc_b}, 10'h0);
        exp_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("rst_no_restart");
        run_frame(0, -1, fa, la, fb, lb);
        chk("after_rst_first_a", fa, 12'hFFF);
        chk("after_rst_last_b", lb, 12'hFF6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
